program_loader: RTL and testbench
=================================

# program_loader

Hardware boot loader that fills the CPU's instruction memory and data memory from an 8-bit byte stream, then releases the CPU by asserting `start_o`. It sits outside the `CPU` instance and drives the same memory contents and start signal that simulation otherwise sets up directly. This lets a board or host interface load a program and input data without backdoor memory access.

## Interface
- `IMEM_WORDS`, 256: instruction memory depth in 32-bit words; word address width is 8.
- `DMEM_WORDS`, 8: data memory depth in 32-bit words (32 bytes); word address width is 3.
- `CMD_IMEM`, 8'hA5: command byte that starts an instruction-memory frame.
- `CMD_DMEM`, 8'h5A: command byte that starts a data-memory frame.
- `CMD_START`, 8'hC3: command byte that releases the CPU.
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `rx_data_i`  in  8  incoming stream byte.
- `rx_valid_i`  in  1  `rx_data_i` is valid.
- `rx_ready_o`  out  1  loader can accept a byte.
- `imem_we_o`  out  1  one-cycle instruction memory write strobe.
- `imem_addr_o`  out  8  instruction word index.
- `imem_data_o`  out  32  instruction word.
- `dmem_we_o`  out  1  one-cycle data memory write strobe.
- `dmem_addr_o`  out  3  data word index; byte address is index*4.
- `dmem_data_o`  out  32  data word. The CPU-side wrapper stores bits [7:0] at byte index*4, little-endian.
- `start_o`  out  1  CPU start; sticky until reset.
- `busy_o`  out  1  a frame is in progress.
- `err_o`  out  1  sticky protocol error.

## Operation
- **Byte acceptance.** A byte is accepted on a rising edge where `rx_valid_i && rx_ready_o`. Cycles with `rx_valid_i` low have no effect.
- **Frame format.** Each frame is: command byte, base byte, count byte, then count×4 payload bytes.
  - Payload words are sent MSB first.
  - A count of 0 means an empty frame: no writes are made and the loader returns to IDLE.
- **States:** IDLE, BASE, COUNT, DATA, DONE.
- **IDLE:**
  - `CMD_IMEM` or `CMD_DMEM`: latch the target and go to BASE.
  - `CMD_START`: go to DONE.
  - Any other byte: set `err_o`, stay in IDLE, discard the byte.
- **BASE:** latch the byte as the word address and go to COUNT.
  - For a dmem frame with base ≥ `DMEM_WORDS`, set `err_o` and mark the frame as discard.
- **COUNT:** load the words-remaining counter (9 bits).
  - Count 0 returns to IDLE; otherwise go to DATA.
- **DATA:**
  - Shift each byte into a 32-bit assembly register and step a 2-bit byte counter.
  - On the 4th byte, write the assembled word (unless the frame is marked discard), increment the address and decrement words-remaining.
  - When words-remaining reaches 0, return to IDLE.
- **Address wrap.** The imem address wraps modulo 256 (0xFF → 0x00). The dmem address wraps modulo 8.
- **DONE:** `start_o`=1 and `rx_ready_o`=0. Only reset leaves this state.
- **Output decodes:**
  - `busy_o` = state is BASE, COUNT or DATA.
  - `rx_ready_o` = 1 in every state except DONE.
- `err_o` never clears except on reset. Frames keep working after an error.

## Timing
- **Reset values.** While `rst_i`=0, every output is 0: `rx_ready_o`, both write strobes, all addresses and data, `start_o`, `busy_o`, `err_o`.
  - The first edge after release sees state IDLE with `rx_ready_o`=1.
- **Write latency.** The write strobe, address and data are registered. They are valid for exactly one cycle, in the cycle after the 4th payload byte is accepted.
  - `imem_we_o` and `dmem_we_o` are never high together.
- **Start latency.** `start_o` rises in the cycle after `CMD_START` is accepted.
- **Throughput.** One byte per cycle with no bubbles. Back-to-back frames are allowed, and the next command byte may follow the last payload byte immediately.
- **Reset mid-frame.** Any partially assembled word is discarded with no write. The state, counters and `err_o` clear immediately, asynchronously.
- **Stale data.** Address and data outputs hold their last written values between strobes. They are don't-care when the strobe is low.

## Test plan
- **Instruction load:**
  - Stimulus: A5 00 02, then 20 08 00 05 and 01 09 50 20, sent back to back.
  - Required: `imem_we_o` pulses twice; writes are (0, 0x20080005) then (1, 0x01095020); `busy_o` drops after the last byte.
- **Data load with input gaps:**
  - Stimulus: 5A 00 01 00 00 00 05, with `rx_valid_i` low for 3 cycles between bytes.
  - Required: one `dmem_we_o` pulse with addr 0, data 0x00000005; no other strobes.
- **Wrap:**
  - Stimulus: A5 FF 02 followed by 8 payload bytes.
  - Required: writes at `imem_addr_o` 0xFF then 0x00.
- **Errors:**
  - Stimulus: byte 0x77 in IDLE. Required: `err_o`=1, state stays IDLE.
  - Stimulus: then 5A 09 01 with 4 payload bytes. Required: payload consumed, no `dmem_we_o`, and a following A5 00 01 frame still writes normally.
- **Start:**
  - Stimulus: C3.
  - Required: `start_o`=1 and `rx_ready_o`=0 from the next cycle; later valid bytes produce no strobes and no state change.
- **Reset mid-word:**
  - Stimulus: A5 00 01 12 34, then assert `rst_i` low.
  - Required: all outputs 0 immediately and no write. After release, A5 00 01 DE AD BE EF writes (0, 0xDEADBEEF).

Source files
------------

// File: rtl/program_loader.sv
// Boot loader: parses a framed byte stream into instruction/data memory word
// writes, then releases the CPU with a sticky start once the start command arrives.
module program_loader #(
    parameter int          IMEM_WORDS = 256,
    parameter int          DMEM_WORDS = 8,
    parameter logic [7:0]  CMD_IMEM   = 8'hA5,
    parameter logic [7:0]  CMD_DMEM   = 8'h5A,
    parameter logic [7:0]  CMD_START  = 8'hC3
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [7:0]                    rx_data_i,
    input  logic                          rx_valid_i,
    output logic                          rx_ready_o,
    output logic                          imem_we_o,
    output logic [$clog2(IMEM_WORDS)-1:0] imem_addr_o,
    output logic [31:0]                   imem_data_o,
    output logic                          dmem_we_o,
    output logic [$clog2(DMEM_WORDS)-1:0] dmem_addr_o,
    output logic [31:0]                   dmem_data_o,
    output logic                          start_o,
    output logic                          busy_o,
    output logic                          err_o
);
    localparam int IAW = $clog2(IMEM_WORDS);
    localparam int DAW = $clog2(DMEM_WORDS);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_BASE  = 3'd1;
    localparam logic [2:0] S_COUNT = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]     state_q,   state_d;
    logic           tgt_q,     tgt_d;       // 1 = data memory frame
    logic           discard_q, discard_d;
    logic [7:0]     addr_q,    addr_d;
    logic [8:0]     remain_q,  remain_d;
    logic [1:0]     bcnt_q,    bcnt_d;
    logic [31:0]    shift_q,   shift_d;
    logic           err_q,     err_d;
    logic           iwe_q,     iwe_d;
    logic [IAW-1:0] iaddr_q,   iaddr_d;
    logic [31:0]    idata_q,   idata_d;
    logic           dwe_q,     dwe_d;
    logic [DAW-1:0] daddr_q,   daddr_d;
    logic [31:0]    ddata_q,   ddata_d;

    logic           accept;
    logic [31:0]    word;
    logic [DAW-1:0] daddr_inc;

    // Gating ready with reset keeps every output low while reset is held,
    // yet lets the first edge after release accept a byte.
    assign rx_ready_o = rst_i && (state_q != S_DONE);
    assign accept     = rx_valid_i && rx_ready_o;
    assign busy_o     = (state_q == S_BASE) || (state_q == S_COUNT) || (state_q == S_DATA);
    assign start_o    = (state_q == S_DONE);
    assign err_o      = err_q;

    assign imem_we_o   = iwe_q;
    assign imem_addr_o = iaddr_q;
    assign imem_data_o = idata_q;
    assign dmem_we_o   = dwe_q;
    assign dmem_addr_o = daddr_q;
    assign dmem_data_o = ddata_q;

    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        discard_d = discard_q;
        addr_d    = addr_q;
        remain_d  = remain_q;
        bcnt_d    = bcnt_q;
        shift_d   = shift_q;
        err_d     = err_q;
        iwe_d     = 1'b0;
        iaddr_d   = iaddr_q;
        idata_d   = idata_q;
        dwe_d     = 1'b0;
        daddr_d   = daddr_q;
        ddata_d   = ddata_q;
        word      = {shift_q[23:0], rx_data_i};
        daddr_inc = addr_q[DAW-1:0] + 1'b1;

        if (accept) begin
            case (state_q)
                S_IDLE: begin
                    if (rx_data_i == CMD_IMEM) begin
                        tgt_d   = 1'b0;
                        state_d = S_BASE;
                    end else if (rx_data_i == CMD_DMEM) begin
                        tgt_d   = 1'b1;
                        state_d = S_BASE;
                    end else if (rx_data_i == CMD_START) begin
                        state_d = S_DONE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                S_BASE: begin
                    addr_d    = rx_data_i;
                    discard_d = 1'b0;
                    if (tgt_q && (32'(rx_data_i) >= 32'(DMEM_WORDS))) begin
                        err_d     = 1'b1;
                        discard_d = 1'b1;
                    end
                    state_d = S_COUNT;
                end
                S_COUNT: begin
                    remain_d = {1'b0, rx_data_i};
                    bcnt_d   = 2'd0;
                    state_d  = (rx_data_i == 8'd0) ? S_IDLE : S_DATA;
                end
                S_DATA: begin
                    shift_d = word;
                    bcnt_d  = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        if (!discard_q) begin
                            if (tgt_q) begin
                                dwe_d   = 1'b1;
                                daddr_d = addr_q[DAW-1:0];
                                ddata_d = word;
                            end else begin
                                iwe_d   = 1'b1;
                                iaddr_d = addr_q[IAW-1:0];
                                idata_d = word;
                            end
                        end
                        // Data addresses wrap within the small data memory.
                        addr_d   = tgt_q ? 8'(daddr_inc) : addr_q + 8'd1;
                        remain_d = remain_q - 9'd1;
                        if (remain_q == 9'd1) state_d = S_IDLE;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= S_IDLE;
            tgt_q     <= 1'b0;
            discard_q <= 1'b0;
            addr_q    <= '0;
            remain_q  <= '0;
            bcnt_q    <= '0;
            shift_q   <= '0;
            err_q     <= 1'b0;
            iwe_q     <= 1'b0;
            iaddr_q   <= '0;
            idata_q   <= '0;
            dwe_q     <= 1'b0;
            daddr_q   <= '0;
            ddata_q   <= '0;
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            discard_q <= discard_d;
            addr_q    <= addr_d;
            remain_q  <= remain_d;
            bcnt_q    <= bcnt_d;
            shift_q   <= shift_d;
            err_q     <= err_d;
            iwe_q     <= iwe_d;
            iaddr_q   <= iaddr_d;
            idata_q   <= idata_d;
            dwe_q     <= dwe_d;
            daddr_q   <= daddr_d;
            ddata_q   <= ddata_d;
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: frame-level model in queues checked every cycle,
// plus literal expectations on the captured write log.
module tb_program_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready, imem_we, dmem_we, start, busy, err;
    logic [7:0]  imem_addr;
    logic [2:0]  dmem_addr;
    logic [31:0] imem_data, dmem_data;

    int errors = 0;
    int checks = 0;

    program_loader dut (
        .clk_i(clk), .rst_i(rst_n),
        .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
        .imem_we_o(imem_we), .imem_addr_o(imem_addr), .imem_data_o(imem_data),
        .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr), .dmem_data_o(dmem_data),
        .start_o(start), .busy_o(busy), .err_o(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        d;
        bit [7:0]  a;
        bit [31:0] w;
    } wr_t;

    // Model state: bytes of the frame in progress, sticky flags, pending write.
    logic [7:0] m_frame[$];
    bit         m_err, m_start;
    bit         exp_i, exp_d;
    bit [7:0]   exp_a;
    bit [31:0]  exp_w;
    wr_t        obs[$];
    logic [7:0] tx[$];
    bit         chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic mdl_reset();
        m_frame.delete();
        m_err = 0; m_start = 0; exp_i = 0; exp_d = 0;
    endtask

    task automatic mdl_byte(input logic [7:0] b);
        int n, k, base, cnt;
        bit isd;
        if (m_frame.size() == 0) begin
            if (b == 8'hA5 || b == 8'h5A) m_frame.push_back(b);
            else if (b == 8'hC3) m_start = 1;
            else m_err = 1;
        end else begin
            m_frame.push_back(b);
            n = m_frame.size();
            isd = (m_frame[0] == 8'h5A);
            if (n == 2) begin
                if (isd && b >= 8) m_err = 1;
            end else if (n == 3) begin
                if (b == 0) m_frame.delete();
            end else if ((n - 3) % 4 == 0) begin
                k    = (n - 3) / 4 - 1;
                base = int'(m_frame[1]);
                cnt  = int'(m_frame[2]);
                if (!(isd && base >= 8)) begin
                    exp_i = !isd;
                    exp_d = isd;
                    exp_a = isd ? 8'((base + k) % 8) : 8'((base + k) % 256);
                    exp_w = {m_frame[n-4], m_frame[n-3], m_frame[n-2], m_frame[n-1]};
                end
                if (k + 1 == cnt) m_frame.delete();
            end
        end
    endtask

    task automatic step(input bit v, input logic [7:0] b);
        @(negedge clk);
        rx_valid = v;
        rx_data  = b;
        @(posedge clk);
        exp_i = 0;
        exp_d = 0;
        if (v && !m_start && rst_n) mdl_byte(b);
    endtask

    task automatic send_tx(input int gap);
        foreach (tx[i]) begin
            step(1'b1, tx[i]);
            for (int g = 0; g < gap; g++) step(1'b0, 8'h00);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, rx_ready, 0);
        chk({tag, "_we"}, {imem_we, dmem_we}, 0);
        chk({tag, "_addr"}, {imem_addr, 5'b0, dmem_addr}, 0);
        chk({tag, "_idata"}, imem_data, 0);
        chk({tag, "_ddata"}, dmem_data, 0);
        chk({tag, "_flags"}, {start, busy, err}, 0);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", rx_ready, !m_start);
            chk("busy", busy, m_frame.size() != 0);
            chk("err", err, m_err);
            chk("start", start, m_start);
            chk("imem_we", imem_we, exp_i);
            chk("dmem_we", dmem_we, exp_d);
            if (exp_i) begin
                chk("imem_addr", imem_addr, exp_a);
                chk("imem_data", imem_data, exp_w);
            end
            if (exp_d) begin
                chk("dmem_addr", dmem_addr, exp_a[2:0]);
                chk("dmem_data", dmem_data, exp_w);
            end
            if (imem_we) obs.push_back('{1'b0, imem_addr, imem_data});
            if (dmem_we) obs.push_back('{1'b1, {5'b0, dmem_addr}, dmem_data});
        end
    end

    initial begin
        mdl_reset();
        #12;
        chk_all_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk_en = 1'b1;

        // Instruction load, back to back.
        obs.delete();
        tx = '{8'hA5, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
        send_tx(0);
        idle(2);
        chk("ild_n", obs.size(), 2);
        if (obs.size() == 2) begin
            chk("ild_w0", {obs[0].d, obs[0].a, obs[0].w}, {1'b0, 8'h00, 32'h20080005});
            chk("ild_w1", {obs[1].d, obs[1].a, obs[1].w}, {1'b0, 8'h01, 32'h01095020});
        end

        // Data load with gaps.
        obs.delete();
        tx = '{8'h5A, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h05};
        send_tx(3);
        idle(2);
        chk("dld_n", obs.size(), 1);
        if (obs.size() == 1)
            chk("dld_w0", {obs[0].d, obs[0].a, obs[0].w}, {1'b1, 8'h00, 32'h00000005});

        // Imem address wrap, then an empty frame.
        obs.delete();
        tx = '{8'hA5, 8'hFF, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
               8'hA5, 8'h10, 8'h00};
        send_tx(0);
        idle(2);
        chk("wrap_n", obs.size(), 2);
        if (obs.size() == 2) begin
            chk("wrap_w0", {obs[0].a, obs[0].w}, {8'hFF, 32'h11223344});
            chk("wrap_w1", {obs[1].a, obs[1].w}, {8'h00, 32'h55667788});
        end

        // Dmem address wrap 7 -> 0.
        obs.delete();
        tx = '{8'h5A, 8'h07, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01, 8'h02, 8'h03, 8'h04};
        send_tx(0);
        idle(1);
        chk("dwrap_n", obs.size(), 2);
        if (obs.size() == 2) chk("dwrap_a", {obs[0].a, obs[1].a}, {8'h07, 8'h00});

        // Bad command, discarded dmem frame, then a normal imem frame.
        obs.delete();
        tx = '{8'h77};
        send_tx(0);
        idle(1);
        chk("err_set", {err, busy}, 2'b10);
        tx = '{8'h5A, 8'h09, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04,
               8'hA5, 8'h00, 8'h01, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
        send_tx(0);
        idle(2);
        chk("err_n", obs.size(), 1);
        if (obs.size() == 1)
            chk("err_w0", {obs[0].d, obs[0].a, obs[0].w}, {1'b0, 8'h00, 32'hCAFEF00D});

        // Start, then ignored traffic.
        obs.delete();
        tx = '{8'hC3, 8'hA5, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
        send_tx(0);
        idle(1);
        chk("start_lit", {start, rx_ready, busy}, 3'b100);
        chk("start_n", obs.size(), 0);

        // Reset mid-word.
        @(negedge clk);
        chk_en = 1'b0;
        rst_n = 1'b0;
        mdl_reset();
        #1 chk_all_zero("rst2");
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk_en = 1'b1;
        obs.delete();
        tx = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34};
        send_tx(0);
        #3;
        chk_en = 1'b0;
        rst_n = 1'b0;
        mdl_reset();
        #1 chk_all_zero("rst3");
        idle(2);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk_en = 1'b1;
        chk("rst3_n", obs.size(), 0);
        tx = '{8'hA5, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_tx(0);
        idle(2);
        chk("rst3_wn", obs.size(), 1);
        if (obs.size() == 1)
            chk("rst3_w0", {obs[0].d, obs[0].a, obs[0].w}, {1'b0, 8'h00, 32'hDEADBEEF});

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
